m68k_bus_target: RTL and testbench
==================================

Name: m68k_bus_target

Overview:
- 68000 bus responder: the target end of the asynchronous AS/UDS/LDS/DTACK protocol that our bus master drives.
- Decodes a fixed address window and serves a word-wide internal RAM with byte-lane writes.
- Asserts DTACK_n after a programmable number of wait states; optionally asserts BERR_n on a bus-cycle timeout.
- Used as an on-board expansion/test target and as the bench responder for master bring-up.

Parameters:
BASE_ADDR, 24'hE80000, byte address of window start; aligned to the window size.
ADDR_W, 10, RAM word-address width; window = 2^(ADDR_W+1) bytes.
WAIT_STATES, 0, c7m falling edges inserted between strobe detection and DTACK assertion (0..15).
BERR_TIMEOUT, 64, c7m falling edges with AS asserted and no DTACK before BERR is asserted (only when the feature is enabled).

Ports:
c200m  in  1  sampling clock, 200 MHz; all logic on its rising edge.
reset  in  1  synchronous active-high reset.
M68K_CLK  in  1  7 MHz bus clock; asynchronous, synchronised internally.
M68K_A  in  23  address A[23:1].
M68K_FC  in  3  function code.
M68K_AS_n  in  1  address strobe.
M68K_UDS_n  in  1  upper data strobe (D[15:8]).
M68K_LDS_n  in  1  lower data strobe (D[7:0]).
M68K_RW  in  1  1 = read, 0 = write.
M68K_D_IN  in  16  data from the bus.
M68K_D_OUT  out  16  read data to the bus.
M68K_D_OE  out  1  data bus drive enable.
M68K_DTACK_n  out  1  data transfer acknowledge; open-drain style, 1 = released.
M68K_BERR_n  out  1  bus error; 1 = released.
hit  out  1  one c200m pulse per completed acknowledged cycle.

Behaviour:
- Synchronisers: AS_n, UDS_n, LDS_n, RW and M68K_CLK each pass through 3-stage synchronisers in c200m. c7m_falling = stage2 high and stage1 low.
- Reset values: DTACK_n=1, BERR_n=1, D_OE=0, D_OUT=0, hit=0, state=IDLE, counters=0. RAM contents are not reset.
- Decode: hit when A[23:ADDR_W+1] == BASE_ADDR[23:ADDR_W+1] and FC != 3'b111. Interrupt-acknowledge cycles are never answered.
- State machine:
  - IDLE: when synced AS_n=0, latch A, RW and the decode result, then go to STROBE. A non-decoded cycle goes to IGNORE.
  - STROBE: wait until synced UDS_n=0 or LDS_n=0.
    - On a read: latch RAM[A[ADDR_W:1]] into D_OUT and set D_OE=1.
    - On a write: latch D_IN and both strobes.
    - Load the wait counter with WAIT_STATES and go to WAIT.
  - WAIT: decrement on each c7m_falling. At 0, go to ACK. With WAIT_STATES=0, ACK is entered on the next c200m cycle.
  - ACK: DTACK_n=0.
    - On a write, commit the latched data to RAM for lanes whose strobe was low: UDS → [15:8], LDS → [7:0]. Exactly one write per cycle.
    - Pulse hit, then go to RELEASE.
  - RELEASE: hold DTACK_n=0 and D_OE. When synced AS_n=1, set DTACK_n=1 and D_OE=0 on the same c200m edge, then go to IDLE.
  - IGNORE: drive nothing. Return to IDLE when synced AS_n=1.
- Latency, strobe detection to DTACK low: 1 c200m cycle plus WAIT_STATES c7m falling edges. For WAIT_STATES=0 this is at most 5 c200m cycles from the strobe pin edge.
- Abort: if synced AS_n returns high in STROBE or WAIT, go to IDLE. Nothing is acknowledged or written, and D_OE is cleared.
- Back-to-back cycles: AS_n low again while in RELEASE is ignored until AS_n has been seen high for at least one c200m cycle.
- Reset mid-cycle: outputs return to their reset values on the next edge, and no RAM write occurs.
- Read-modify-write (AS held, DS toggles): unsupported. The acknowledge covers the first data phase only.

Optional Feature:
M68K_TARGET_BERR_EN
- Enabled: a timeout counter counts c7m_falling edges while synced AS_n=0 and DTACK_n=1. This covers IGNORE and also STROBE/WAIT.
- On reaching BERR_TIMEOUT: BERR_n=0, state goes to RELEASE without DTACK and without any RAM write, and BERR_n returns to 1 when AS_n is synced high.
- The counter clears in IDLE.
- Disabled: BERR_n is tied to 1, and unmapped cycles hang until AS_n is released.

Test Plan:
- Write word 16'hBEEF to 24'hE80010 (UDS=LDS=0), then read the same address → D_OUT=16'hBEEF, D_OE high only while DTACK_n low, hit pulses twice.
- Byte write 8'h12 with UDS only to 24'hE80010, then read → 16'h12EF.
- WAIT_STATES=3: read → DTACK_n falls exactly after 3 c7m falling edges following strobe detection, not earlier.
- Read at 24'hF00000 → DTACK_n stays 1 and D_OE stays 0. With the feature enabled and BERR_TIMEOUT=64, BERR_n falls on the 64th c7m falling edge and rises after AS_n goes high.
- Cycle with FC=3'b111 inside the window → no response.
- Assert reset during WAIT of a write → DTACK_n=1 and D_OE=0 next cycle; a subsequent read returns the old RAM value.

Source files
------------

// File: rtl/m68k_bus_target.sv
// rtl/m68k_bus_target.sv - 68000 bus target: window decode, word RAM, DTACK after wait states
// Optional bus-error timeout enabled by defining M68K_TARGET_BERR_EN.
module m68k_bus_target #(
  parameter logic [23:0] BASE_ADDR    = 24'hE80000,
  parameter int          ADDR_W       = 10,
  parameter int          WAIT_STATES  = 0,
  parameter int          BERR_TIMEOUT = 64
) (
  input  logic        c200m,
  input  logic        reset,
  input  logic        M68K_CLK,
  input  logic [23:1] M68K_A,
  input  logic [2:0]  M68K_FC,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  input  logic [15:0] M68K_D_IN,
  output logic [15:0] M68K_D_OUT,
  output logic        M68K_D_OE,
  output logic        M68K_DTACK_n,
  output logic        M68K_BERR_n,
  output logic        hit
);

  typedef enum logic [2:0] {
    S_IDLE, S_STROBE, S_WAIT, S_ACK, S_RELEASE, S_IGNORE
  } state_t;

  if (WAIT_STATES < 0 || WAIT_STATES > 15 || BERR_TIMEOUT < 1) begin : g_param_check
    $error("m68k_bus_target: WAIT_STATES must be 0..15 and BERR_TIMEOUT >= 1");
  end

  logic [2:0] as_s, uds_s, lds_s, rw_s, clk_s;
  logic       as_sync, uds_sync, lds_sync, rw_sync, c7m_falling;

  always_ff @(posedge c200m) begin
    if (reset) begin
      as_s  <= 3'b111;
      uds_s <= 3'b111;
      lds_s <= 3'b111;
      rw_s  <= 3'b111;
      clk_s <= 3'b000;
    end else begin
      as_s  <= {as_s[1:0],  M68K_AS_n};
      uds_s <= {uds_s[1:0], M68K_UDS_n};
      lds_s <= {lds_s[1:0], M68K_LDS_n};
      rw_s  <= {rw_s[1:0],  M68K_RW};
      clk_s <= {clk_s[1:0], M68K_CLK};
    end
  end

  assign as_sync     = as_s[2];
  assign uds_sync    = uds_s[2];
  assign lds_sync    = lds_s[2];
  assign rw_sync     = rw_s[2];
  assign c7m_falling = clk_s[2] & ~clk_s[1];

  logic decode;
  assign decode = (M68K_A[23:ADDR_W+1] == BASE_ADDR[23:ADDR_W+1]) && (M68K_FC != 3'b111);

  logic [15:0]       mem [0:(1<<ADDR_W)-1];
  state_t            state;
  logic [ADDR_W-1:0] addr_l;
  logic              rw_l, uds_l, lds_l;
  logic [15:0]       wdata_l;
  logic [3:0]        wait_cnt;
  logic              mem_we;

`ifdef M68K_TARGET_BERR_EN
  localparam int TO_W = $clog2(BERR_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
`endif

  always_ff @(posedge c200m) begin
    if (reset) begin
      state        <= S_IDLE;
      M68K_DTACK_n <= 1'b1;
      M68K_BERR_n  <= 1'b1;
      M68K_D_OE    <= 1'b0;
      M68K_D_OUT   <= 16'h0000;
      hit          <= 1'b0;
      addr_l       <= '0;
      rw_l         <= 1'b1;
      uds_l        <= 1'b1;
      lds_l        <= 1'b1;
      wdata_l      <= 16'h0000;
      wait_cnt     <= 4'd0;
`ifdef M68K_TARGET_BERR_EN
      to_cnt       <= '0;
`endif
    end else begin
      hit <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!as_sync) begin
            addr_l <= M68K_A[ADDR_W:1];
            rw_l   <= rw_sync;
            state  <= decode ? S_STROBE : S_IGNORE;
          end
        end
        S_STROBE: begin
          if (as_sync) begin
            M68K_D_OE <= 1'b0;
            state     <= S_IDLE;
          end else if (!uds_sync || !lds_sync) begin
            if (rw_l) begin
              M68K_D_OUT <= mem[addr_l];
              M68K_D_OE  <= 1'b1;
            end else begin
              wdata_l <= M68K_D_IN;
              uds_l   <= uds_sync;
              lds_l   <= lds_sync;
            end
            wait_cnt <= 4'(WAIT_STATES);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (as_sync) begin
            M68K_D_OE <= 1'b0;
            state     <= S_IDLE;
          end else if (wait_cnt == 4'd0) begin
            M68K_DTACK_n <= 1'b0;
            state        <= S_ACK;
          end else if (c7m_falling) begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ACK: begin
          hit   <= 1'b1;
          state <= S_RELEASE;
        end
        S_RELEASE: begin
          // Leaving only on AS_n high guarantees IDLE sees the strobe released.
          if (as_sync) begin
            M68K_DTACK_n <= 1'b1;
            M68K_BERR_n  <= 1'b1;
            M68K_D_OE    <= 1'b0;
            state        <= S_IDLE;
          end
        end
        S_IGNORE: begin
          if (as_sync) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

`ifdef M68K_TARGET_BERR_EN
      // Timeout overrides any same-edge progress toward an acknowledge.
      if (state == S_IDLE) begin
        to_cnt <= '0;
      end else if ((state == S_STROBE || state == S_WAIT || state == S_IGNORE) &&
                   !as_sync && c7m_falling) begin
        if (to_cnt == TO_W'(BERR_TIMEOUT - 1)) begin
          M68K_BERR_n  <= 1'b0;
          M68K_DTACK_n <= 1'b1;
          M68K_D_OE    <= 1'b0;
          state        <= S_RELEASE;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end
`endif
    end
  end

  assign mem_we = (state == S_ACK) && !rw_l && !reset;

  always_ff @(posedge c200m) begin
    if (mem_we) begin
      if (!uds_l) mem[addr_l][15:8] <= wdata_l[15:8];
      if (!lds_l) mem[addr_l][7:0]  <= wdata_l[7:0];
    end
  end

endmodule

// File: tb/tb_m68k_bus_target.sv
// tb/tb_m68k_bus_target.sv - scoreboard bench for m68k_bus_target (WAIT_STATES 0 and 3 instances)
`timescale 1ns/1ps
module tb_m68k_bus_target;

  logic        c200m = 1'b0;
  logic        reset = 1'b1;
  logic        M68K_CLK = 1'b0;
  logic [23:1] M68K_A = '0;
  logic [2:0]  M68K_FC = 3'b101;
  logic        M68K_AS_n = 1'b1;
  logic        M68K_UDS_n = 1'b1;
  logic        M68K_LDS_n = 1'b1;
  logic        M68K_RW = 1'b1;
  logic [15:0] M68K_D_IN = '0;

  logic [15:0] dout0, dout3;
  logic        doe0, doe3, dtack0, dtack3, berr0, berr3, hit0, hit3;

  always #2.5 c200m = ~c200m;
  always #70  M68K_CLK = ~M68K_CLK;

  m68k_bus_target #(.WAIT_STATES(0)) dut0 (
    .c200m(c200m), .reset(reset), .M68K_CLK(M68K_CLK), .M68K_A(M68K_A), .M68K_FC(M68K_FC),
    .M68K_AS_n(M68K_AS_n), .M68K_UDS_n(M68K_UDS_n), .M68K_LDS_n(M68K_LDS_n), .M68K_RW(M68K_RW),
    .M68K_D_IN(M68K_D_IN), .M68K_D_OUT(dout0), .M68K_D_OE(doe0), .M68K_DTACK_n(dtack0),
    .M68K_BERR_n(berr0), .hit(hit0));

  m68k_bus_target #(.WAIT_STATES(3)) dut3 (
    .c200m(c200m), .reset(reset), .M68K_CLK(M68K_CLK), .M68K_A(M68K_A), .M68K_FC(M68K_FC),
    .M68K_AS_n(M68K_AS_n), .M68K_UDS_n(M68K_UDS_n), .M68K_LDS_n(M68K_LDS_n), .M68K_RW(M68K_RW),
    .M68K_D_IN(M68K_D_IN), .M68K_D_OUT(dout3), .M68K_D_OE(doe3), .M68K_DTACK_n(dtack3),
    .M68K_BERR_n(berr3), .hit(hit3));

  int checks = 0;
  int errors = 0;
  int fall_cnt = 0;
  int hit_cnt0 = 0, hit_cnt3 = 0;
  int exp_hits0 = 0, exp_hits3 = 0;
  logic [15:0] mdl0 [int];
  logic [15:0] mdl3 [int];
  logic [15:0] q0 [$];
  logic [15:0] q3 [$];

  always @(negedge M68K_CLK) fall_cnt++;

  always @(negedge c200m) begin
    if (hit0 === 1'b1) hit_cnt0++;
    if (hit3 === 1'b1) hit_cnt3++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int widx(input logic [23:0] addr);
    return int'(addr[10:1]);
  endfunction

  // Full cycle, paced by the slower instance so both complete; ds = {UDS_n, LDS_n}.
  task automatic bus_cycle(input logic [23:0] addr, input logic rd, input logic [1:0] ds,
                           input logic [15:0] wd);
    int n, n0, falls0;
    logic [15:0] e0, e3;
    @(posedge M68K_CLK); #1;
    M68K_A = addr[23:1]; M68K_FC = 3'b101; M68K_RW = rd; M68K_D_IN = wd; M68K_AS_n = 1'b0;
    if (rd) begin
      q0.push_back(mdl0[widx(addr)]);
      q3.push_back(mdl3[widx(addr)]);
    end
    repeat (3) @(negedge c200m);
    #1;
    {M68K_UDS_n, M68K_LDS_n} = ds;
    falls0 = fall_cnt;
    n = 0; n0 = 0;
    while (n < 400) begin
      @(negedge c200m);
      n++;
      if (n0 == 0 && dtack0 == 1'b0) n0 = n;
      if (dtack3 == 1'b0) break;
    end
    check("ack3", {31'd0, dtack3}, 32'd0);
    check("lat0_le5", {31'd0, (n0 >= 1 && n0 <= 5)}, 32'd1);
    check("ws3_falls", fall_cnt - falls0, 32'd3);
    if (rd) begin
      e0 = q0.pop_front();
      e3 = q3.pop_front();
      check("rd0", {16'd0, dout0}, {16'd0, e0});
      check("rd3", {16'd0, dout3}, {16'd0, e3});
      check("oe_at_ack", {30'd0, doe0, doe3}, 32'd3);
    end else begin
      if (!ds[1]) begin mdl0[widx(addr)][15:8] = wd[15:8]; mdl3[widx(addr)][15:8] = wd[15:8]; end
      if (!ds[0]) begin mdl0[widx(addr)][7:0]  = wd[7:0];  mdl3[widx(addr)][7:0]  = wd[7:0];  end
    end
    exp_hits0++; exp_hits3++;
    M68K_AS_n = 1'b1; M68K_UDS_n = 1'b1; M68K_LDS_n = 1'b1; M68K_RW = 1'b1;
    repeat (6) @(negedge c200m);
    check("release", {28'd0, dtack0, dtack3, doe0, doe3}, 32'hC);
    repeat (2) @(negedge c200m);
  endtask

  task automatic no_response(input string tag, input logic [23:0] addr, input logic [2:0] fc,
                             input int hold);
    logic bad;
    @(posedge M68K_CLK); #1;
    M68K_A = addr[23:1]; M68K_FC = fc; M68K_RW = 1'b1;
    M68K_AS_n = 1'b0; M68K_UDS_n = 1'b0; M68K_LDS_n = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge c200m);
      if (dtack0 !== 1'b1 || dtack3 !== 1'b1 || doe0 !== 1'b0 || doe3 !== 1'b0 ||
          berr0 !== 1'b1 || hit0 !== 1'b0) bad = 1'b1;
    end
    check(tag, {31'd0, bad}, 32'd0);
    M68K_AS_n = 1'b1; M68K_UDS_n = 1'b1; M68K_LDS_n = 1'b1; M68K_FC = 3'b101;
    repeat (8) @(negedge c200m);
  endtask

  initial begin
    logic [23:0] ra;
    logic [15:0] rd;
    int n, base;

    repeat (5) @(negedge c200m);
    check("rst_dtack", {31'd0, dtack0}, 32'd1);
    check("rst_berr", {31'd0, berr0}, 32'd1);
    check("rst_oe", {31'd0, doe0}, 32'd0);
    check("rst_dout", {16'd0, dout0}, 32'd0);
    check("rst_hit", {31'd0, hit0}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge c200m);

    bus_cycle(24'hE80010, 1'b0, 2'b00, 16'hBEEF);
    bus_cycle(24'hE80010, 1'b1, 2'b00, 16'h0000);
    check("hit_twice", hit_cnt0, 32'd2);

    bus_cycle(24'hE80010, 1'b0, 2'b01, 16'h1234);
    bus_cycle(24'hE80010, 1'b1, 2'b00, 16'h0000);
    bus_cycle(24'hE80010, 1'b0, 2'b10, 16'hAA77);
    bus_cycle(24'hE80010, 1'b1, 2'b00, 16'h0000);

    for (int i = 0; i < 4; i++) begin
      ra = 24'hE80000 | {13'd0, 10'($urandom_range(0, 1023)), 1'b0};
      rd = 16'($urandom);
      bus_cycle(ra, 1'b0, 2'b00, rd);
      bus_cycle(ra, 1'b1, 2'b00, 16'h0000);
    end

    no_response("fc7_noresp", 24'hE80010, 3'b111, 60);

`ifdef M68K_TARGET_BERR_EN
    @(posedge M68K_CLK); #1;
    M68K_A = 24'hF00000 >> 1; M68K_RW = 1'b1;
    M68K_AS_n = 1'b0; M68K_UDS_n = 1'b0; M68K_LDS_n = 1'b0;
    base = fall_cnt;
    n = 0;
    while (n < 3000 && berr0 !== 1'b0) begin
      @(negedge c200m);
      n++;
    end
    check("berr_fall", {31'd0, berr0}, 32'd0);
    check("berr_edges", fall_cnt - base, 32'd64);
    check("berr_nodtack", {30'd0, dtack0, doe0}, 32'd2);
    repeat (2) @(negedge c200m);
    check("berr3_fall", {31'd0, berr3}, 32'd0);
    M68K_AS_n = 1'b1; M68K_UDS_n = 1'b1; M68K_LDS_n = 1'b1;
    repeat (6) @(negedge c200m);
    check("berr_rise", {30'd0, berr0, berr3}, 32'd3);
`else
    no_response("unmapped_noresp", 24'hF00000, 3'b101, 300);
`endif

    bus_cycle(24'hE80020, 1'b0, 2'b00, 16'hA5A5);
    @(posedge M68K_CLK); #1;
    M68K_A = 24'hE80020 >> 1; M68K_FC = 3'b101; M68K_RW = 1'b0; M68K_D_IN = 16'h0000;
    M68K_AS_n = 1'b0;
    repeat (3) @(negedge c200m);
    #1;
    M68K_UDS_n = 1'b0; M68K_LDS_n = 1'b0;
    repeat (12) @(negedge c200m);
    check("rst_pre", {30'd0, dtack0, dtack3}, 32'd1);
    mdl0[widx(24'hE80020)] = 16'h0000;
    exp_hits0++;
    reset = 1'b1;
    @(negedge c200m);
    check("rst_mid", {28'd0, dtack3, doe3, dtack0, doe0}, 32'hA);
    reset = 1'b0;
    M68K_AS_n = 1'b1; M68K_UDS_n = 1'b1; M68K_LDS_n = 1'b1; M68K_RW = 1'b1;
    repeat (6) @(negedge c200m);
    bus_cycle(24'hE80020, 1'b1, 2'b00, 16'h0000);

    check("hits0", hit_cnt0, exp_hits0);
    check("hits3", hit_cnt3, exp_hits3);
    check("sb_empty", q0.size() + q3.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
